button_press_classifier: RTL
============================

Name: button_press_classifier

Overview:
- Sits directly downstream of the debounce stage in the button processing chain, in parallel with the edge-to-pulse stage.
- Consumes the debounced, synchronised button level and classifies each gesture as exactly one of three events: short press, long press or double click.
- Each event is reported as a single-cycle pulse on its own output, so downstream logic (LED toggles, mode selectors) can use it as a clock enable.

Parameters:
- sim, 1'b0: when 1, the timing constants below are replaced by LONG_TICKS=16 and GAP_TICKS=8 for fast simulation.
- LONG_TICKS, 50_000_000: consecutive high samples that qualify a long press (0.5 s at 100 MHz).
- GAP_TICKS, 25_000_000: maximum low samples between two presses for a double click.
- CNT_W, 26: counter width; must satisfy 2^CNT_W > max(LONG_TICKS, GAP_TICKS).

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-low reset, sampled on rising clk.
- in, input, 1: debounced button level, 1 = pressed, already synchronous to clk.
- short_press, output, 1: one-cycle pulse for a single short press.
- long_press, output, 1: one-cycle pulse when a hold reaches LONG_TICKS.
- double_click, output, 1: one-cycle pulse on release of the second press.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=ARM, cnt=0.
  - short_press, long_press and double_click are all 0; busy=1.
  - Reset mid-gesture abandons the gesture and emits no event.
- All outputs are registered. Event pulses are high for exactly one cycle. At most one event pulse is high in any cycle.
- "Sample" means the value of in at a rising edge. cnt saturates and never wraps.
- State transitions:
  - ARM: in==0 -> IDLE. A button held through reset therefore produces no event until it is released.
  - IDLE: in==1 -> PRESS1, cnt=1.
  - PRESS1:
    - in==1 and cnt==LONG_TICKS-1 -> LONG_HOLD, with long_press=1 in the following cycle. The long_press pulse follows the LONG_TICKS-th consecutive high sample.
    - in==1 otherwise -> cnt+1.
    - in==0 -> WAIT2, cnt=1.
  - LONG_HOLD: in==0 -> IDLE. No further events while the button is held (no auto-repeat).
  - WAIT2:
    - in==1 -> PRESS2.
    - in==0 and cnt==GAP_TICKS-1 -> IDLE, with short_press=1 in the following cycle. The short_press pulse follows the GAP_TICKS-th consecutive low sample.
    - Otherwise -> cnt+1.
  - PRESS2: in==0 -> IDLE, with double_click=1 in the following cycle.
    - The duration of the second press is irrelevant; a long second press still yields double_click only.
    - cnt is held at 0 in PRESS2.
- Latencies: short_press arrives GAP_TICKS cycles after release. double_click arrives 1 cycle after the second release.
- A third press starting while the double_click pulse is high is seen from IDLE in the next cycle as a new gesture.
- Unused state encodings recover to ARM.

Test Plan (sim=1, LONG_TICKS=16, GAP_TICKS=8):
1. Reset low 3 cycles with in=1, then release reset, hold in=1 for 20 cycles, then in=0 -> no event pulse at all; busy=1 until the first low sample, then busy=0.
2. From IDLE: in=1 for 5 samples, then in=0 held -> exactly one short_press pulse on the cycle after the 8th low sample; no other pulses; busy falls on that same cycle.
3. in=1 for 16 samples -> long_press pulse on the cycle after the 16th high sample. Continue holding 30 more cycles -> no further pulse; release -> still none.
4. in=1 for 3 samples, 0 for 4 samples, 1 for 25 samples, then 0 -> single double_click one cycle after the final release; no short_press or long_press.
5. in=1 for 3, 0 for exactly 8 -> short_press. Then in=1 on the very next sample -> new gesture starts in PRESS1. Separately, 0 for 7 then 1 -> double_click path taken.
6. Reset asserted for 1 cycle mid-WAIT2 (cnt=4), with in=0 -> state goes to ARM then IDLE; no short_press is ever emitted for the aborted gesture.

Source files
------------

// File: rtl/button_press_classifier.sv
// Button gesture classifier: turns a debounced, synchronous button level into
// one-cycle short_press / long_press / double_click pulses.
// A gesture is a first press followed by either a long hold, a release that
// times out (short press), or a second press within the gap window (double
// click). A button held through reset is ignored until it is released.
module button_press_classifier #(
   parameter bit sim        = 1'b0,
   parameter int LONG_TICKS = 50_000_000,
   parameter int GAP_TICKS  = 25_000_000,
   parameter int CNT_W      = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic busy
);

   // Simulation builds shrink the timing windows so gestures take tens of cycles.
   localparam int LONG_EFF = sim ? 16 : LONG_TICKS;
   localparam int GAP_EFF  = sim ? 8  : GAP_TICKS;

   // Terminal counts: cnt holds the number of samples already seen in the
   // current run, so the final sample of a run arrives while cnt == N-1.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_EFF - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_ARM       = 3'd0,
      ST_IDLE      = 3'd1,
      ST_PRESS1    = 3'd2,
      ST_LONG_HOLD = 3'd3,
      ST_WAIT2     = 3'd4,
      ST_PRESS2    = 3'd5
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc_d;
   logic             short_q;
   logic             long_q;
   logic             dbl_q;
   logic             busy_q;

   // Saturating increment so the run counter can never wrap.
   always_comb begin
      cnt_inc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   end

   // Gesture FSM with registered event pulses and busy flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_ARM;
         cnt_q   <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         // Pulses default low; busy defaults high and is cleared on every
         // path whose next state is IDLE.
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         busy_q  <= 1'b1;
         case (state_q)
            ST_ARM: begin
               if (!in) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (in) begin
                  state_q <= ST_PRESS1;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            ST_PRESS1: begin
               if (in) begin
                  if (cnt_q == LONG_LAST) begin
                     state_q <= ST_LONG_HOLD;
                     cnt_q   <= '0;
                     long_q  <= 1'b1;
                  end else begin
                     cnt_q   <= cnt_inc_d;
                  end
               end else begin
                  state_q <= ST_WAIT2;
                  cnt_q   <= CNT_ONE;
               end
            end
            ST_LONG_HOLD: begin
               // No auto-repeat: simply wait for the release.
               if (!in) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_WAIT2: begin
               if (in) begin
                  state_q <= ST_PRESS2;
                  cnt_q   <= '0;
               end else if (cnt_q == GAP_LAST) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  short_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_inc_d;
               end
            end
            ST_PRESS2: begin
               // Length of the second press does not matter.
               cnt_q <= '0;
               if (!in) begin
                  state_q <= ST_IDLE;
                  dbl_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_ARM;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign short_press  = short_q;
   assign long_press   = long_q;
   assign double_click = dbl_q;
   assign busy         = busy_q;

endmodule
